// File: rtl/mgnt_pkg.sv
// Shared definitions for the magnet pulse monitor:
// one-hot FSM states and fault codes.
package mgnt_pkg;

   typedef enum logic [5:0] {
      S_IDLE  = 6'b000001,
      S_CHG   = 6'b000010,
      S_GAP1  = 6'b000100,
      S_DCHG  = 6'b001000,
      S_GAP2  = 6'b010000,
      S_FAULT = 6'b100000
   } state_e;

   localparam logic [2:0] FLT_NONE      = 3'd0;
   localparam logic [2:0] FLT_OVERLAP   = 3'd1;
   localparam logic [2:0] FLT_CHG_LONG  = 3'd2;
   localparam logic [2:0] FLT_DCHG_LONG = 3'd3;
   localparam logic [2:0] FLT_ORDER     = 3'd4;

endpackage

// File: rtl/mgnt_sat_counter.sv
// Saturating up-counter with load-to-one and increment.
// Holds at all-ones instead of wrapping.
module mgnt_sat_counter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load1,
   input  logic             inc,
   output logic [WIDTH-1:0] cnt
);

   logic [WIDTH-1:0] cnt_d;
   logic [WIDTH-1:0] cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (load1) begin
         cnt_d = WIDTH'(1);
      end else if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/mgnt_pulse_monitor.sv
// Receive-side observer of the CHG/DCHG pulse train:
// measures widths/gaps, counts pairs, latches interlock faults.
module mgnt_pulse_monitor
   import mgnt_pkg::*;
#(
   parameter int unsigned DATABUS_WIDTH = 32
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic                     ENABLE,
   input  logic                     CHG_IN,
   input  logic                     DCHG_IN,
   input  logic [DATABUS_WIDTH-1:0] MAX_CHG_PLEN,
   input  logic [DATABUS_WIDTH-1:0] MAX_DCHG_PLEN,
   input  logic [DATABUS_WIDTH-1:0] IDLE_TIMEOUT,
   input  logic                     CLR_FAULT,
   output logic [DATABUS_WIDTH-1:0] MEAS_CHG_PLEN,
   output logic [DATABUS_WIDTH-1:0] MEAS_CHG_DLEN,
   output logic [DATABUS_WIDTH-1:0] MEAS_DCHG_PLEN,
   output logic [DATABUS_WIDTH-1:0] MEAS_DCHG_DLEN,
   output logic [DATABUS_WIDTH-1:0] PAIR_CNT,
   output logic                     MEAS_VALID,
   output logic                     SEQ_DONE,
   output logic                     BUSY,
   output logic                     FAULT,
   output logic [2:0]               FAULT_CODE
);

   localparam int unsigned DW = DATABUS_WIDTH;

   state_e            state_d, state_q;
   logic              chg_r_q, dchg_r_q;
   logic [DW-1:0]     cnt;
   logic              cnt_load, cnt_inc;
   logic [DW-1:0]     meas_chg_plen_d, meas_chg_plen_q;
   logic [DW-1:0]     meas_chg_dlen_d, meas_chg_dlen_q;
   logic [DW-1:0]     meas_dchg_plen_d, meas_dchg_plen_q;
   logic [DW-1:0]     meas_dchg_dlen_d, meas_dchg_dlen_q;
   logic [DW-1:0]     pair_cnt_d, pair_cnt_q;
   logic              meas_valid_d, meas_valid_q;
   logic              seq_done_d, seq_done_q;
   logic              busy_d, busy_q;
   logic              fault_d, fault_q;
   logic [2:0]        fault_code_d, fault_code_q;
   logic              raise;
   logic [2:0]        code;

   mgnt_sat_counter #(.WIDTH(DW)) u_cnt (
      .clk   (CLK),
      .rst   (RESET),
      .load1 (cnt_load),
      .inc   (cnt_inc),
      .cnt   (cnt)
   );

   always_comb begin
      state_d          = state_q;
      cnt_load         = 1'b0;
      cnt_inc          = 1'b0;
      meas_chg_plen_d  = meas_chg_plen_q;
      meas_chg_dlen_d  = meas_chg_dlen_q;
      meas_dchg_plen_d = meas_dchg_plen_q;
      meas_dchg_dlen_d = meas_dchg_dlen_q;
      pair_cnt_d       = pair_cnt_q;
      meas_valid_d     = 1'b0;
      seq_done_d       = 1'b0;
      // Lags the state by a cycle so BUSY still covers the SEQ_DONE strobe.
      busy_d           = (state_q != S_IDLE);
      fault_d          = fault_q;
      fault_code_d     = fault_code_q;
      raise            = 1'b0;
      code             = FLT_NONE;

      if (state_q == S_FAULT) begin
         if (CLR_FAULT && !chg_r_q && !dchg_r_q) begin
            state_d      = S_IDLE;
            fault_d      = 1'b0;
            fault_code_d = FLT_NONE;
         end
      end else if (!ENABLE) begin
         state_d = S_IDLE;
      end else if (chg_r_q && dchg_r_q) begin
         raise = 1'b1;
         code  = FLT_OVERLAP;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (chg_r_q) begin
                  state_d    = S_CHG;
                  cnt_load   = 1'b1;
                  pair_cnt_d = '0;
               end else if (dchg_r_q) begin
                  raise = 1'b1;
                  code  = FLT_ORDER;
               end
            end
            S_CHG: begin
               if (chg_r_q) begin
                  if ((MAX_CHG_PLEN != '0) && (cnt == MAX_CHG_PLEN)) begin
                     raise = 1'b1;
                     code  = FLT_CHG_LONG;
                  end else begin
                     cnt_inc = 1'b1;
                  end
               end else begin
                  meas_chg_plen_d = cnt;
                  state_d         = S_GAP1;
                  cnt_load        = 1'b1;
               end
            end
            S_GAP1: begin
               if (dchg_r_q) begin
                  meas_chg_dlen_d = cnt;
                  state_d         = S_DCHG;
                  cnt_load        = 1'b1;
               end else if (chg_r_q) begin
                  raise = 1'b1;
                  code  = FLT_ORDER;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
            S_DCHG: begin
               if (dchg_r_q) begin
                  if ((MAX_DCHG_PLEN != '0) && (cnt == MAX_DCHG_PLEN)) begin
                     raise = 1'b1;
                     code  = FLT_DCHG_LONG;
                  end else begin
                     cnt_inc = 1'b1;
                  end
               end else begin
                  meas_dchg_plen_d = cnt;
                  if (pair_cnt_q != '1) begin
                     pair_cnt_d = pair_cnt_q + DW'(1);
                  end
                  meas_valid_d = 1'b1;
                  state_d      = S_GAP2;
                  cnt_load     = 1'b1;
               end
            end
            S_GAP2: begin
               if (chg_r_q) begin
                  meas_dchg_dlen_d = cnt;
                  state_d          = S_CHG;
                  cnt_load         = 1'b1;
               end else if (dchg_r_q) begin
                  raise = 1'b1;
                  code  = FLT_ORDER;
               end else if ((IDLE_TIMEOUT != '0) && (cnt == IDLE_TIMEOUT)) begin
                  seq_done_d = 1'b1;
                  state_d    = S_IDLE;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      if (raise) begin
         state_d      = S_FAULT;
         fault_d      = 1'b1;
         fault_code_d = code;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q          <= S_IDLE;
         chg_r_q          <= 1'b0;
         dchg_r_q         <= 1'b0;
         meas_chg_plen_q  <= '0;
         meas_chg_dlen_q  <= '0;
         meas_dchg_plen_q <= '0;
         meas_dchg_dlen_q <= '0;
         pair_cnt_q       <= '0;
         meas_valid_q     <= 1'b0;
         seq_done_q       <= 1'b0;
         busy_q           <= 1'b0;
         fault_q          <= 1'b0;
         fault_code_q     <= FLT_NONE;
      end else begin
         state_q          <= state_d;
         chg_r_q          <= CHG_IN;
         dchg_r_q         <= DCHG_IN;
         meas_chg_plen_q  <= meas_chg_plen_d;
         meas_chg_dlen_q  <= meas_chg_dlen_d;
         meas_dchg_plen_q <= meas_dchg_plen_d;
         meas_dchg_dlen_q <= meas_dchg_dlen_d;
         pair_cnt_q       <= pair_cnt_d;
         meas_valid_q     <= meas_valid_d;
         seq_done_q       <= seq_done_d;
         busy_q           <= busy_d;
         fault_q          <= fault_d;
         fault_code_q     <= fault_code_d;
      end
   end

   assign MEAS_CHG_PLEN  = meas_chg_plen_q;
   assign MEAS_CHG_DLEN  = meas_chg_dlen_q;
   assign MEAS_DCHG_PLEN = meas_dchg_plen_q;
   assign MEAS_DCHG_DLEN = meas_dchg_dlen_q;
   assign PAIR_CNT       = pair_cnt_q;
   assign MEAS_VALID     = meas_valid_q;
   assign SEQ_DONE       = seq_done_q;
   assign BUSY           = busy_q;
   assign FAULT          = fault_q;
   assign FAULT_CODE     = fault_code_q;

endmodule

// File: tb/tb_mgnt_pulse_monitor.sv
// Scoreboard bench for mgnt_pulse_monitor: directed pulse trains push
// expected events; a negedge monitor pops and compares them.
module tb_mgnt_pulse_monitor;

   localparam int W   = 32;
   // input register + output register between a raw edge and a strobe
   localparam int LAT = 2;

   typedef enum logic [1:0] {EV_MEAS, EV_SEQ, EV_FAULT} ev_e;

   typedef struct {
      ev_e kind;
      int  chg_p;
      int  chg_d;
      int  dchg_p;
      int  dchg_d;
      bit  chk_d;
      int  pair;
      int  code;
      int  cyc;
   } exp_t;

   exp_t sb[$];

   logic         CLK = 1'b0;
   logic         RESET, ENABLE, CHG_IN, DCHG_IN, CLR_FAULT;
   logic [W-1:0] MAX_CHG_PLEN, MAX_DCHG_PLEN, IDLE_TIMEOUT;
   logic [W-1:0] MEAS_CHG_PLEN, MEAS_CHG_DLEN;
   logic [W-1:0] MEAS_DCHG_PLEN, MEAS_DCHG_DLEN, PAIR_CNT;
   logic         MEAS_VALID, SEQ_DONE, BUSY, FAULT;
   logic [2:0]   FAULT_CODE;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   mgnt_pulse_monitor #(.DATABUS_WIDTH(W)) dut (
      .CLK            (CLK),
      .RESET          (RESET),
      .ENABLE         (ENABLE),
      .CHG_IN         (CHG_IN),
      .DCHG_IN        (DCHG_IN),
      .MAX_CHG_PLEN   (MAX_CHG_PLEN),
      .MAX_DCHG_PLEN  (MAX_DCHG_PLEN),
      .IDLE_TIMEOUT   (IDLE_TIMEOUT),
      .CLR_FAULT      (CLR_FAULT),
      .MEAS_CHG_PLEN  (MEAS_CHG_PLEN),
      .MEAS_CHG_DLEN  (MEAS_CHG_DLEN),
      .MEAS_DCHG_PLEN (MEAS_DCHG_PLEN),
      .MEAS_DCHG_DLEN (MEAS_DCHG_DLEN),
      .PAIR_CNT       (PAIR_CNT),
      .MEAS_VALID     (MEAS_VALID),
      .SEQ_DONE       (SEQ_DONE),
      .BUSY           (BUSY),
      .FAULT          (FAULT),
      .FAULT_CODE     (FAULT_CODE)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic cmp(input string nm, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   function automatic void exp_meas(int cp, int cd, int dp, int pair,
                                    bit chk, int dd);
      exp_t e;
      e = '{EV_MEAS, cp, cd, dp, dd, chk, pair, 0, 0};
      sb.push_back(e);
   endfunction

   function automatic void exp_seq(int at, int pair, int dd);
      exp_t e;
      e = '{EV_SEQ, 0, 0, 0, dd, 1'b1, pair, 0, at};
      sb.push_back(e);
   endfunction

   function automatic void exp_fault(int code);
      exp_t e;
      e = '{EV_FAULT, 0, 0, 0, 0, 1'b0, 0, code, 0};
      sb.push_back(e);
   endfunction

   task automatic take(input ev_e k, output exp_t e, output bit ok);
      ok = 1'b0;
      e  = '{EV_MEAS, 0, 0, 0, 0, 1'b0, 0, 0, 0};
      if (sb.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)",
                  int'(k), cyc);
      end else begin
         e = sb.pop_front();
         cmp("event_kind", W'(int'(k)), W'(int'(e.kind)));
         ok = (e.kind == k);
      end
   endtask

   logic fault_prev = 1'b0;
   logic seq_prev   = 1'b0;

   always @(negedge CLK) begin
      exp_t e;
      bit   ok;
      if (MEAS_VALID || SEQ_DONE)
         cmp("strobe_excl", W'(MEAS_VALID & SEQ_DONE), '0);
      if (seq_prev)
         cmp("busy_after_seq", W'(BUSY), '0);
      if (MEAS_VALID) begin
         take(EV_MEAS, e, ok);
         if (ok) begin
            cmp("meas_chg_plen", MEAS_CHG_PLEN, W'(e.chg_p));
            cmp("meas_chg_dlen", MEAS_CHG_DLEN, W'(e.chg_d));
            cmp("meas_dchg_plen", MEAS_DCHG_PLEN, W'(e.dchg_p));
            cmp("meas_pair_cnt", PAIR_CNT, W'(e.pair));
            if (e.chk_d)
               cmp("meas_dchg_dlen", MEAS_DCHG_DLEN, W'(e.dchg_d));
         end
      end
      if (SEQ_DONE) begin
         take(EV_SEQ, e, ok);
         if (ok) begin
            cmp("seq_cycle", W'(cyc), W'(e.cyc));
            cmp("seq_pair_cnt", PAIR_CNT, W'(e.pair));
            cmp("seq_dchg_dlen", MEAS_DCHG_DLEN, W'(e.dchg_d));
            cmp("seq_busy", W'(BUSY), W'(1));
         end
      end
      if (FAULT && !fault_prev) begin
         take(EV_FAULT, e, ok);
         if (ok)
            cmp("fault_code", W'(FAULT_CODE), W'(e.code));
      end
      fault_prev = FAULT;
      seq_prev   = SEQ_DONE;
   end

   task automatic drive(input logic c, input logic d, input int n);
      CHG_IN  = c;
      DCHG_IN = d;
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic clear_fault();
      drive(1'b0, 1'b0, 2);
      CLR_FAULT = 1'b1;
      drive(1'b0, 1'b0, 1);
      CLR_FAULT = 1'b0;
      drive(1'b0, 1'b0, 2);
   endtask

   task automatic check_zero(input string tag);
      cmp({tag, "_chg_plen"}, MEAS_CHG_PLEN, '0);
      cmp({tag, "_chg_dlen"}, MEAS_CHG_DLEN, '0);
      cmp({tag, "_dchg_plen"}, MEAS_DCHG_PLEN, '0);
      cmp({tag, "_dchg_dlen"}, MEAS_DCHG_DLEN, '0);
      cmp({tag, "_pair_cnt"}, PAIR_CNT, '0);
      cmp({tag, "_meas_valid"}, W'(MEAS_VALID), '0);
      cmp({tag, "_seq_done"}, W'(SEQ_DONE), '0);
      cmp({tag, "_busy"}, W'(BUSY), '0);
      cmp({tag, "_fault"}, W'(FAULT), '0);
      cmp({tag, "_fault_code"}, W'(FAULT_CODE), '0);
   endtask

   initial begin
      repeat (20000) @(posedge CLK);
      $display("FAIL watchdog: got no finish expected finish within 20000 cycles");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET         = 1'b1;
      ENABLE        = 1'b1;
      CHG_IN        = 1'b0;
      DCHG_IN       = 1'b0;
      CLR_FAULT     = 1'b0;
      MAX_CHG_PLEN  = '0;
      MAX_DCHG_PLEN = '0;
      IDLE_TIMEOUT  = W'(50);
      repeat (3) @(posedge CLK);
      #1;
      RESET = 1'b0;
      check_zero("reset");

      // three 10/5/8/20 pairs, then timeout after 50 low cycles
      for (int i = 0; i < 3; i++) begin
         exp_meas(10, 5, 8, i + 1, 1'b1, (i == 0) ? 0 : 20);
         drive(1'b1, 1'b0, 10);
         drive(1'b0, 1'b0, 5);
         drive(1'b0, 1'b1, 8);
         if (i < 2) drive(1'b0, 1'b0, 20);
      end
      exp_seq(cyc + 50 + LAT, 3, 20);
      drive(1'b0, 1'b0, 60);

      // charge exactly at the limit is legal
      MAX_CHG_PLEN = W'(10);
      exp_meas(10, 5, 8, 1, 1'b1, 20);
      drive(1'b1, 1'b0, 10);
      drive(1'b0, 1'b0, 5);
      drive(1'b0, 1'b1, 8);
      exp_seq(cyc + 50 + LAT, 1, 20);
      drive(1'b0, 1'b0, 60);

      // one cycle over the limit
      exp_fault(2);
      drive(1'b1, 1'b0, 11);
      drive(1'b0, 1'b0, 3);
      cmp("frozen_chg_plen", MEAS_CHG_PLEN, W'(10));
      cmp("fault_latched", W'(FAULT), W'(1));
      clear_fault();
      cmp("clr_after_long", W'(FAULT), '0);

      // overlap inside a charge pulse
      exp_fault(1);
      drive(1'b1, 1'b0, 3);
      drive(1'b1, 1'b1, 1);
      drive(1'b0, 1'b0, 3);
      clear_fault();

      // overlap coinciding with over-length
      exp_fault(1);
      drive(1'b1, 1'b0, 10);
      drive(1'b1, 1'b1, 1);
      drive(1'b0, 1'b0, 3);
      clear_fault();

      // discharge with no charge, clear ignored while DCHG high
      exp_fault(4);
      drive(1'b0, 1'b1, 4);
      CLR_FAULT = 1'b1;
      drive(1'b0, 1'b1, 1);
      CLR_FAULT = 1'b0;
      drive(1'b0, 1'b1, 2);
      cmp("clr_ignored_fault", W'(FAULT), W'(1));
      cmp("clr_ignored_code", W'(FAULT_CODE), W'(4));
      drive(1'b0, 1'b0, 3);
      clear_fault();
      cmp("clr_fault", W'(FAULT), '0);
      cmp("clr_code", W'(FAULT_CODE), '0);
      cmp("clr_busy", W'(BUSY), '0);

      // enable dropped mid-discharge
      MAX_CHG_PLEN = '0;
      exp_meas(4, 2, 6, 1, 1'b0, 0);
      drive(1'b1, 1'b0, 4);
      drive(1'b0, 1'b0, 2);
      drive(1'b0, 1'b1, 6);
      drive(1'b0, 1'b0, 3);
      drive(1'b1, 1'b0, 4);
      drive(1'b0, 1'b0, 2);
      drive(1'b0, 1'b1, 3);
      ENABLE = 1'b0;
      drive(1'b0, 1'b1, 2);
      drive(1'b0, 1'b0, 4);
      ENABLE = 1'b1;
      drive(1'b0, 1'b0, 2);
      cmp("en_pair_cnt", PAIR_CNT, W'(1));
      cmp("en_dchg_dlen", MEAS_DCHG_DLEN, W'(3));
      cmp("en_dchg_plen", MEAS_DCHG_PLEN, W'(6));
      cmp("en_busy", W'(BUSY), '0);

      // reset in the middle of GAP1
      drive(1'b1, 1'b0, 5);
      drive(1'b0, 1'b0, 3);
      RESET = 1'b1;
      drive(1'b0, 1'b0, 1);
      RESET = 1'b0;
      check_zero("rst_mid");

      // no timeout: 1000-cycle gap is measured on the next charge
      IDLE_TIMEOUT = '0;
      exp_meas(3, 2, 2, 1, 1'b1, 0);
      drive(1'b1, 1'b0, 3);
      drive(1'b0, 1'b0, 2);
      drive(1'b0, 1'b1, 2);
      drive(1'b0, 1'b0, 1000);
      cmp("long_gap_busy", W'(BUSY), W'(1));
      exp_meas(3, 2, 2, 2, 1'b1, 1000);
      drive(1'b1, 1'b0, 3);
      drive(1'b0, 1'b0, 2);
      drive(1'b0, 1'b1, 2);
      drive(1'b0, 1'b0, 5);
      ENABLE = 1'b0;
      drive(1'b0, 1'b0, 3);

      cmp("sb_drained", W'(sb.size()), '0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mgnt_pulse_monitor.md
Name: mgnt_pulse_monitor

Overview:
- Receive-side observer for the magnet charge/discharge pulse train (CHG/DCHG lines driving the magnet power stage).
- Decodes the pulse stream back into measured charge width, post-charge gap, discharge width, post-discharge gap and pair count.
- Enforces hardware interlocks: overlap, over-length and ordering. Any violation latches FAULT, which the power stage uses to abort.
- Sits beside the pulse generator on the same clock. Results are read by the control bus.

Parameters:
DATABUS_WIDTH, 32, width of all length/limit inputs, measurement outputs and internal counters

Ports:
CLK  input  1  system clock
RESET  input  1  synchronous, active-high reset
ENABLE  input  1  monitoring enable; low forces IDLE and suppresses fault detection
CHG_IN  input  1  charging pulse line (synchronous to CLK)
DCHG_IN  input  1  discharging pulse line (synchronous to CLK)
MAX_CHG_PLEN  input  DATABUS_WIDTH  max legal charge width in cycles; 0 = no limit
MAX_DCHG_PLEN  input  DATABUS_WIDTH  max legal discharge width in cycles; 0 = no limit
IDLE_TIMEOUT  input  DATABUS_WIDTH  post-discharge low cycles that end a sequence; 0 = never
CLR_FAULT  input  1  clears latched fault
MEAS_CHG_PLEN  output  DATABUS_WIDTH  last charge width
MEAS_CHG_DLEN  output  DATABUS_WIDTH  last charge-fall to discharge-rise gap
MEAS_DCHG_PLEN  output  DATABUS_WIDTH  last discharge width
MEAS_DCHG_DLEN  output  DATABUS_WIDTH  last discharge-fall to next charge-rise gap
PAIR_CNT  output  DATABUS_WIDTH  completed pairs in current/last sequence
MEAS_VALID  output  1  1-cycle strobe: a pair completed
SEQ_DONE  output  1  1-cycle strobe: sequence ended by timeout
BUSY  output  1  state not IDLE
FAULT  output  1  latched fault
FAULT_CODE  output  3  0 none, 1 overlap, 2 charge over-length, 3 discharge over-length, 4 order violation

Behaviour:
- Reset: all outputs 0, state IDLE, CNT 0, input registers CHG_R/DCHG_R 0.
- Inputs are registered once (CHG_R, DCHG_R). All decisions use the registered values. Widths and gaps are exact cycle counts of the raw inputs: an N-cycle high pulse measures N.
- States: IDLE, CHG, GAP1, DCHG, GAP2, FAULT. All counts are DATABUS_WIDTH bits and saturate at all-ones.
- IDLE: on CHG_R go to CHG, CNT<=1, PAIR_CNT<=0. On DCHG_R alone, raise fault 4.
- CHG: while CHG_R, CNT+1. If CNT==MAX_CHG_PLEN (nonzero) and CHG_R is still high, raise fault 2. On CHG_R low, MEAS_CHG_PLEN<=CNT, go to GAP1, CNT<=1.
- GAP1: on DCHG_R, MEAS_CHG_DLEN<=CNT, go to DCHG, CNT<=1. On CHG_R, raise fault 4. Otherwise CNT+1.
- DCHG: mirror of CHG using MAX_DCHG_PLEN (fault 3). On fall, MEAS_DCHG_PLEN<=CNT, PAIR_CNT+1, MEAS_VALID=1 for one cycle, go to GAP2, CNT<=1.
- GAP2: on CHG_R, MEAS_DCHG_DLEN<=CNT, go to CHG, CNT<=1. On DCHG_R, raise fault 4. If IDLE_TIMEOUT nonzero and CNT==IDLE_TIMEOUT, SEQ_DONE=1, go to IDLE; MEAS_DCHG_DLEN is unchanged.
- Overlap: CHG_R&&DCHG_R in any non-FAULT state raises fault 1. Overlap has priority over every other fault raised in the same cycle.
- Raising a fault: FAULT<=1, FAULT_CODE<=code, go to FAULT. The first fault wins. Measurement registers freeze.
- FAULT: leave only when CLR_FAULT=1 and both registered inputs are low; then FAULT<=0, FAULT_CODE<=0, go to IDLE. CLR_FAULT in any other state is ignored.
- ENABLE=0: from any non-FAULT state go to IDLE next cycle, without strobes. FAULT state and latch are retained.
- RESET mid-sequence: immediate return to reset values on the next edge, including the fault latch.
- MEAS_VALID and SEQ_DONE are never asserted in the same cycle.

Decomposition:
- Package mgnt_pkg: state encoding (one-hot, 6 bits); FAULT_CODE constants FLT_NONE, FLT_OVERLAP, FLT_CHG_LONG, FLT_DCHG_LONG, FLT_ORDER.
- One sub-module, mgnt_sat_counter: saturating up-counter with load-1 and increment, width DATABUS_WIDTH.

Test Plan:
- Sequence: CHG 10 high, 5 low, DCHG 8 high, 20 low, repeated 3 times, IDLE_TIMEOUT=50 -> MEAS_VALID three times with 10/5/8; MEAS_DCHG_DLEN=20; PAIR_CNT=3; SEQ_DONE exactly 50 low cycles after the last DCHG fall; BUSY drops the cycle after.
- MAX_CHG_PLEN=10, CHG high 11 cycles -> FAULT=1, code 2. With CHG high exactly 10 cycles -> no fault.
- CHG and DCHG high together for 1 cycle during CHG state -> code 1. Same cycle as a CHG over-length -> code 1.
- DCHG pulse with no preceding CHG -> code 4. CLR_FAULT while DCHG is high is ignored; after DCHG falls, CLR_FAULT returns to IDLE with FAULT=0.
- ENABLE dropped mid-DCHG -> IDLE, no MEAS_VALID, PAIR_CNT held. RESET mid-GAP1 -> all outputs 0.
- IDLE_TIMEOUT=0 with a 1000-cycle gap -> remains in GAP2; the next CHG rise gives MEAS_DCHG_DLEN=1000.
